serial_byte_receiver: RTL and testbench
=======================================

Name: serial_byte_receiver

Overview:
- 8N1 UART receive front end: converts the raw asynchronous line from the Arduino into validated bytes with a one-cycle strobe.
- Sits directly upstream of the byte-assembly/LED stage, which consumes rx_valid and rx_byte.
- Adds input synchronisation, glitch rejection on the start bit, framing-error detection and break handling.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per bit (CLK_FREQ/BAUD); legal range >= 8.
- HALF_BIT, (CLKS_PER_BIT-1)/2, integer division; counter value at which the start bit is re-checked at mid-bit.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rx_serial  in  1  raw asynchronous UART line; idle high.
- rx_valid  out  1  one-cycle pulse; a good byte is on rx_byte.
- rx_byte  out  8  last good byte, LSB received first; held between pulses.
- frame_err  out  1  one-cycle pulse; stop bit sampled 0.
- busy  out  1  high in every state except IDLE.
- state_dbg  out  3  current FSM state encoding, for debug.

Behaviour:
- Reset: sync flops = 1, rx_byte = 0x00, rx_valid = 0, frame_err = 0, busy = 0, FSM = IDLE, counters = 0. Reset mid-frame aborts the frame: no pulse, rx_byte unchanged from its reset value.
- Synchroniser: two-flop chain; the FSM sees only the second flop (rx_s).
- Bit counter clk_cnt: width clog2(CLKS_PER_BIT). bit_idx: 3 bits.
- FSM encodings: IDLE=0, START=1, DATA=2, STOP=3, CLEANUP=4, BREAK=5.
- IDLE: clk_cnt = 0, bit_idx = 0. Next state is START when rx_s == 0.
- START: clk_cnt increments until it reaches HALF_BIT. At that cycle:
  - if rx_s == 0, go to DATA with clk_cnt = 0;
  - otherwise go to IDLE (glitch rejected, no output activity).
- DATA: clk_cnt counts 0..CLKS_PER_BIT-1. When clk_cnt == CLKS_PER_BIT-1:
  - shift the sample into shift register bit bit_idx;
  - clk_cnt = 0;
  - after bit_idx == 7, go to STOP; otherwise bit_idx++.
- STOP: when clk_cnt == CLKS_PER_BIT-1, sample the line.
  - Sample 1: rx_byte <= shift register and rx_valid = 1 for the next cycle only; go to CLEANUP.
  - Sample 0: frame_err = 1 for one cycle; rx_byte unchanged; go to BREAK.
- CLEANUP: exactly one cycle, then IDLE. A new start bit is only detected from IDLE, so the minimum gap between frames is 1 cycle after the stop sample.
- BREAK: stay until rx_s == 1, then IDLE. This covers a held-low break condition and prevents a false start.
- Latency: rx_valid rises the cycle after the stop-bit mid-sample. That is (2 + HALF_BIT + 1 + 9*CLKS_PER_BIT + 1) clk after the rx_serial falling edge, give or take one cycle of synchroniser phase.
- rx_valid and frame_err are never high in the same cycle.
- busy = (state != IDLE).

Optional Feature:
- Macro RX_MAJORITY_VOTE_EN.
- Defined:
  - a 3-bit shift register captures rx_s every clk;
  - every sample point uses the 2-of-3 majority of that register: the START mid-check, each DATA sample and the STOP sample;
  - a single-cycle glitch at a sample point is ignored;
  - adds no latency to state transitions.
- Undefined: each sample point uses rx_s directly.

Test Plan (CLKS_PER_BIT=16, HALF_BIT=7, ideal 16-clk bit times unless noted):
- Send 0xA5, stop=1 -> exactly one rx_valid pulse; rx_byte=0xA5 from that cycle on; frame_err stays 0; busy high for about 10 bit times, then 0.
- Back-to-back 0x00 then 0xFF with no idle gap -> two rx_valid pulses about 160 clk apart; rx_byte=0x00, then 0xFF.
- rx_serial low for 3 clk, then high -> FSM returns to IDLE; no rx_valid or frame_err; rx_byte unchanged.
- Send 0x3C with stop bit=0, line then held low for 40 clk -> one frame_err pulse; no rx_valid; rx_byte keeps its previous value; FSM stays in BREAK (state_dbg=5) until the line goes high; next frame 0x11 is received correctly.
- Assert rst for 1 clk during bit 4 of 0x7E, then send 0x42 -> no pulse for 0x7E; rx_byte=0x00 until 0x42 is received, then 0x42.
- With RX_MAJORITY_VOTE_EN, send 0x55 with a 1-clk inverted glitch at each data-bit mid-sample -> rx_byte=0x55. Without the macro -> corrupted byte.

Source files
------------

// File: rtl/serial_byte_receiver.sv
// serial_byte_receiver: 8N1 UART receive front end.
// Synchronises the raw line, rejects short start glitches, samples each bit at
// mid-bit, flags framing errors and parks in BREAK while the line is held low.
//
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   rx_serial  raw asynchronous UART line (idle high)
//   rx_valid   one-cycle pulse, a good byte is on rx_byte
//   rx_byte    last good byte (LSB received first), held between pulses
//   frame_err  one-cycle pulse, stop bit sampled low
//   busy       high whenever the FSM is not in IDLE
//   state_dbg  current FSM state encoding
//
// Optional feature: define RX_MAJORITY_VOTE_EN to take every sample point
// (start mid-check, data bits, stop bit) from a 2-of-3 vote over the last
// three synchronised line values instead of the single synchronised bit.
`timescale 1ns/1ps

module serial_byte_receiver #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned HALF_BIT     = (CLKS_PER_BIT - 1) / 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_serial,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err,
    output logic       busy,
    output logic [2:0] state_dbg
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        CLEANUP = 3'd4,
        BREAK   = 3'd5
    } state_t;

    state_t           state, state_next;
    logic             sync_meta, rx_s;
    logic [CNT_W-1:0] clk_cnt, cnt_next;
    logic [2:0]       bit_idx, idx_next;
    logic [7:0]       shift_reg, shift_next;
    logic [7:0]       byte_next;
    logic             valid_next, ferr_next;
    logic             sample_c;

    // Two-flop synchroniser; idle-high reset value avoids a false start.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= 1'b1;
            rx_s      <= 1'b1;
        end else begin
            sync_meta <= rx_serial;
            rx_s      <= sync_meta;
        end
    end

`ifdef RX_MAJORITY_VOTE_EN
    logic [2:0] vote_sr;

    // History of the synchronised line; a single-cycle glitch is outvoted.
    always_ff @(posedge clk) begin
        if (rst) begin
            vote_sr <= 3'b111;
        end else begin
            vote_sr <= {vote_sr[1:0], rx_s};
        end
    end

    assign sample_c = (vote_sr[0] & vote_sr[1]) |
                      (vote_sr[0] & vote_sr[2]) |
                      (vote_sr[1] & vote_sr[2]);
`else
    assign sample_c = rx_s;
`endif

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'h00;
            rx_byte   <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            clk_cnt   <= cnt_next;
            bit_idx   <= idx_next;
            shift_reg <= shift_next;
            rx_byte   <= byte_next;
            rx_valid  <= valid_next;
            frame_err <= ferr_next;
            busy      <= (state_next != IDLE);
        end
    end

    assign state_dbg = state;

    // Next-state and next-datapath logic.
    always_comb begin
        state_next = state;
        cnt_next   = clk_cnt;
        idx_next   = bit_idx;
        shift_next = shift_reg;
        byte_next  = rx_byte;
        valid_next = 1'b0;
        ferr_next  = 1'b0;

        case (state)
            IDLE: begin
                cnt_next = '0;
                idx_next = 3'd0;
                if (!rx_s) begin
                    state_next = START;
                end
            end
            START: begin
                // Re-check the start bit at mid-bit; a high line means a glitch.
                if (clk_cnt == CNT_HALF) begin
                    cnt_next   = '0;
                    state_next = sample_c ? IDLE : DATA;
                end else begin
                    cnt_next = clk_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (clk_cnt == CNT_LAST) begin
                    cnt_next            = '0;
                    shift_next[bit_idx] = sample_c;
                    if (bit_idx == 3'd7) begin
                        idx_next   = 3'd0;
                        state_next = STOP;
                    end else begin
                        idx_next = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_next = clk_cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (clk_cnt == CNT_LAST) begin
                    cnt_next = '0;
                    if (sample_c) begin
                        byte_next  = shift_reg;
                        valid_next = 1'b1;
                        state_next = CLEANUP;
                    end else begin
                        ferr_next  = 1'b1;
                        state_next = BREAK;
                    end
                end else begin
                    cnt_next = clk_cnt + CNT_W'(1);
                end
            end
            CLEANUP: begin
                state_next = IDLE;
            end
            BREAK: begin
                // Hold here while the line stays low so a break is not a start bit.
                if (rx_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_byte_receiver.sv
// Testbench for serial_byte_receiver with CLKS_PER_BIT=16, HALF_BIT=7.
`timescale 1ns/1ps

module tb_serial_byte_receiver;

    localparam int unsigned CPB  = 16;
    localparam int unsigned HALF = 7;
    localparam int          NV   = 7;

    logic       clk;
    logic       rst;
    logic       rx_serial;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       frame_err;
    logic       busy;
    logic [2:0] state_dbg;

    serial_byte_receiver #(
        .CLKS_PER_BIT(CPB),
        .HALF_BIT    (HALF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_serial(rx_serial),
        .rx_valid (rx_valid),
        .rx_byte  (rx_byte),
        .frame_err(frame_err),
        .busy     (busy),
        .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         gap;
        int         exp_valid;
        int         exp_ferr;
        logic [7:0] exp_byte;
    } vec_t;

    int         n_checks = 0;
    int         n_err    = 0;
    int         cyc      = 0;
    int         n_valid  = 0;
    int         n_ferr   = 0;
    int         n_overlap = 0;
    int         busy_cyc = 0;
    int         valid_t_q[$];
    logic [7:0] byte_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Observe output pulses away from the active edge.
    always @(negedge clk) begin
        if (rx_valid) begin
            n_valid <= n_valid + 1;
            valid_t_q.push_back(cyc);
            byte_q.push_back(rx_byte);
        end
        if (frame_err) n_ferr <= n_ferr + 1;
        if (rx_valid && frame_err) n_overlap <= n_overlap + 1;
        if (busy) busy_cyc <= busy_cyc + 1;
    end

    task automatic check_eq(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic drive_bit(input logic v, input logic glitch);
        for (int c = 0; c < int'(CPB); c++) begin
            @(negedge clk);
            rx_serial = (glitch && c == 8) ? ~v : v;
        end
    endtask

    task automatic drive_level(input logic v, input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            rx_serial = v;
        end
    endtask

    // One 8N1 frame followed by gap idle-high cycles.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int gap, input logic glitch);
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i], glitch);
        drive_bit(stop, 1'b0);
        drive_level(1'b1, gap);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_eq({name, " idle"}, int'(busy), 0);
        check_eq({name, " state"}, int'(state_dbg), 0);
    endtask

    vec_t       vec[NV];
    logic [7:0] exp_last;
    logic [7:0] exp_q[$];
    int         v0, f0, b0, s0, q0, nf;

    initial begin
        vec[0] = '{8'hA5, 1'b1, 20, 1, 0, 8'hA5};
        vec[1] = '{8'h00, 1'b1, 20, 1, 0, 8'h00};
        vec[2] = '{8'hFF, 1'b1, 20, 1, 0, 8'hFF};
        vec[3] = '{8'h3C, 1'b0, 20, 0, 1, 8'hFF};
        vec[4] = '{8'h11, 1'b1, 20, 1, 0, 8'h11};
        vec[5] = '{8'h80, 1'b1, 5,  1, 0, 8'h80};
        vec[6] = '{8'h01, 1'b0, 10, 0, 1, 8'h80};

        rst       = 1'b1;
        rx_serial = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("reset rx_byte", int'(rx_byte), 0);
        check_eq("reset rx_valid", int'(rx_valid), 0);
        check_eq("reset frame_err", int'(frame_err), 0);
        check_eq("reset busy", int'(busy), 0);
        check_eq("reset state", int'(state_dbg), 0);
        rst = 1'b0;
        drive_level(1'b1, 5);

        // Table-driven frames.
        for (int i = 0; i < NV; i++) begin
            v0 = n_valid; f0 = n_ferr; b0 = busy_cyc;
            send_frame(vec[i].data, vec[i].stop, vec[i].gap, 1'b0);
            wait_idle($sformatf("vec%0d", i));
            check_eq($sformatf("vec%0d valid", i), n_valid - v0, vec[i].exp_valid);
            check_eq($sformatf("vec%0d frame_err", i), n_ferr - f0, vec[i].exp_ferr);
            check_eq($sformatf("vec%0d rx_byte", i), int'(rx_byte), int'(vec[i].exp_byte));
            if (i == 0) check_range("vec0 busy cycles", busy_cyc - b0, 150, 158);
        end
        exp_last = 8'h80;

        // Short low glitch on the line is rejected at the mid-bit check.
        v0 = n_valid; f0 = n_ferr;
        drive_level(1'b0, 3);
        drive_level(1'b1, 2);
        check_eq("glitch in START", int'(state_dbg), 1);
        drive_level(1'b1, 40);
        check_eq("glitch state", int'(state_dbg), 0);
        check_eq("glitch valid", n_valid - v0, 0);
        check_eq("glitch frame_err", n_ferr - f0, 0);
        check_eq("glitch rx_byte", int'(rx_byte), int'(exp_last));

        // Bad stop bit followed by a held-low break.
        v0 = n_valid; f0 = n_ferr;
        send_frame(8'h3C, 1'b0, 0, 1'b0);
        drive_level(1'b0, 40);
        check_eq("break state", int'(state_dbg), 5);
        check_eq("break busy", int'(busy), 1);
        check_eq("break frame_err", n_ferr - f0, 1);
        check_eq("break valid", n_valid - v0, 0);
        check_eq("break rx_byte", int'(rx_byte), int'(exp_last));
        drive_level(1'b1, 10);
        check_eq("break exit state", int'(state_dbg), 0);
        v0 = n_valid;
        send_frame(8'h11, 1'b1, 20, 1'b0);
        wait_idle("after break");
        check_eq("after break valid", n_valid - v0, 1);
        check_eq("after break rx_byte", int'(rx_byte), 8'h11);

        // Back-to-back frames with no idle gap.
        s0 = valid_t_q.size();
        send_frame(8'h00, 1'b1, 0, 1'b0);
        send_frame(8'hFF, 1'b1, 20, 1'b0);
        wait_idle("b2b");
        check_eq("b2b pulses", valid_t_q.size() - s0, 2);
        if (valid_t_q.size() >= s0 + 2) begin
            check_range("b2b spacing", valid_t_q[s0 + 1] - valid_t_q[s0], 159, 161);
            check_eq("b2b byte0", int'(byte_q[s0]), 8'h00);
            check_eq("b2b byte1", int'(byte_q[s0 + 1]), 8'hFF);
        end
        check_eq("b2b rx_byte", int'(rx_byte), 8'hFF);

        // One-cycle inverted glitch at every data-bit mid-sample.
        v0 = n_valid;
        send_frame(8'h55, 1'b1, 20, 1'b1);
        wait_idle("vote");
        check_eq("vote valid", n_valid - v0, 1);
`ifdef RX_MAJORITY_VOTE_EN
        check_eq("vote rx_byte", int'(rx_byte), 8'h55);
`else
        n_checks++;
        if (rx_byte == 8'h55) begin
            n_err++;
            $display("FAIL novote rx_byte: got 0x%0h, expected a corrupted byte (not 0x55)", rx_byte);
        end
`endif

        // Randomised frames against a queue of expected received bytes.
        q0 = byte_q.size(); f0 = n_ferr; nf = 0;
        exp_q.delete();
        for (int i = 0; i < 24; i++) begin
            logic [7:0] d;
            logic       st;
            int         g;
            d  = 8'($urandom);
            st = ($urandom_range(0, 3) != 0);
            g  = st ? int'($urandom_range(0, 12)) : int'($urandom_range(4, 15));
            if (st) exp_q.push_back(d);
            else nf++;
            send_frame(d, st, g, 1'b0);
        end
        wait_idle("random");
        check_eq("random pulses", byte_q.size() - q0, exp_q.size());
        check_eq("random frame_err", n_ferr - f0, nf);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (q0 + i < byte_q.size())
                check_eq($sformatf("random byte%0d", i), int'(byte_q[q0 + i]), int'(exp_q[i]));
        end
        if (exp_q.size() > 0) check_eq("random rx_byte", int'(rx_byte), int'(exp_q[exp_q.size() - 1]));

        // Reset in the middle of bit 4 of 0x7E aborts the frame.
        v0 = n_valid; f0 = n_ferr;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'($unsigned(8'h7E >> i)), 1'b0);
        drive_level(1'b1, 8);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("midrst state", int'(state_dbg), 0);
        check_eq("midrst rx_byte", int'(rx_byte), 0);
        drive_level(1'b1, 200);
        check_eq("midrst valid", n_valid - v0, 0);
        check_eq("midrst frame_err", n_ferr - f0, 0);
        check_eq("midrst rx_byte hold", int'(rx_byte), 0);
        send_frame(8'h42, 1'b1, 20, 1'b0);
        wait_idle("midrst");
        check_eq("midrst next valid", n_valid - v0, 1);
        check_eq("midrst next rx_byte", int'(rx_byte), 8'h42);

        check_eq("valid/frame_err overlap", n_overlap, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_err);
        $fatal(1);
    end

endmodule
